// File: rtl/acc_cpu_pkg.sv
// rtl/acc_cpu_pkg.sv - opcode constants and FSM state type for the accumulator core
package acc_cpu_pkg;

   localparam int OPW = 4;

   localparam logic [OPW-1:0] OP_NOP  = 4'h0;
   localparam logic [OPW-1:0] OP_LD   = 4'h1;
   localparam logic [OPW-1:0] OP_ADD  = 4'h2;
   localparam logic [OPW-1:0] OP_SUB  = 4'h3;
   localparam logic [OPW-1:0] OP_AND  = 4'h4;
   localparam logic [OPW-1:0] OP_OR   = 4'h5;
   localparam logic [OPW-1:0] OP_STO  = 4'h6;
   localparam logic [OPW-1:0] OP_JMP  = 4'h7;
   localparam logic [OPW-1:0] OP_JZ   = 4'h8;
   localparam logic [OPW-1:0] OP_JC   = 4'h9;
   localparam logic [OPW-1:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DECODE = 2'd1,
      ST_MEM    = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

endpackage

// File: rtl/acc_cpu_alu.sv
// rtl/acc_cpu_alu.sv - combinational ALU: result, carry/borrow out and zero for the accumulator core
import acc_cpu_pkg::*;

module acc_cpu_alu #(
   parameter int DW = 8
) (
   input  logic [DW-1:0]  a,
   input  logic [DW-1:0]  b,
   input  logic [OPW-1:0] op,
   output logic [DW-1:0]  result,
   output logic           cout,
   output logic           zero
);

   logic [DW:0] sum;
   logic [DW:0] diff;

   // The extra top bit of the difference is the unsigned borrow.
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      result = a;
      cout   = 1'b0;
      case (op)
         OP_LD:   result = b;
         OP_ADD:  {cout, result} = sum;
         OP_SUB:  {cout, result} = diff;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         default: result = a;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/acc_cpu_core.sv
// rtl/acc_cpu_core.sv - fetch/decode/execute accumulator core; ACC_CPU_CARRY_EN enables the carry flag and JC
import acc_cpu_pkg::*;

module acc_cpu_core #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          RESET,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic [AW-1:0] pc,
   output logic [DW-1:0] acc,
   output logic [DW-1:0] ir,
   output logic          zero,
   output logic          carry,
   output logic          halted,
   output logic          instr_done
);

   localparam logic [AW-1:0] PC_ONE = 1;

   state_t         state;
   logic [OPW-1:0] op;
   logic [AW-1:0]  op_addr;
   logic           is_mem_op;
   logic           accept;
   logic [DW-1:0]  alu_result;
   logic           alu_cout;
   logic           alu_zero;

   assign op        = ir[DW-1 -: OPW];
   assign op_addr   = ir[AW-1:0];
   assign is_mem_op = (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB) ||
                      (op == OP_AND) || (op == OP_OR) || (op == OP_STO);

   // Reset gates the request so an in-flight transaction is dropped, writes included.
   assign mem_req   = ((state == ST_FETCH) || (state == ST_MEM)) && !RESET;
   assign mem_we    = (state == ST_MEM) && (op == OP_STO);
   assign mem_addr  = (state == ST_FETCH) ? pc : op_addr;
   assign mem_wdata = acc;
   assign accept    = mem_req && mem_ready;

   assign halted     = (state == ST_HALT);
   assign instr_done = !RESET && (((state == ST_DECODE) && !is_mem_op) ||
                                  ((state == ST_MEM) && accept));

   acc_cpu_alu #(.DW(DW)) u_alu (
      .a      (acc),
      .b      (mem_rdata),
      .op     (op),
      .result (alu_result),
      .cout   (alu_cout),
      .zero   (alu_zero)
   );

`ifdef ACC_CPU_CARRY_EN
   logic carry_q;
   assign carry = carry_q;

   always_ff @(posedge clk) begin
      if (RESET) begin
         carry_q <= 1'b0;
      end else if ((state == ST_MEM) && accept && ((op == OP_ADD) || (op == OP_SUB))) begin
         carry_q <= alu_cout;
      end
   end
`else
   logic unused_cout;
   assign unused_cout = alu_cout;
   assign carry = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (RESET) begin
         state <= ST_FETCH;
         pc    <= '0;
         acc   <= '0;
         ir    <= '0;
         zero  <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (accept) begin
                  ir    <= mem_rdata;
                  pc    <= pc + PC_ONE;
                  state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               state <= ST_FETCH;
               case (op)
                  OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_STO: state <= ST_MEM;
                  OP_JMP: pc <= op_addr;
                  OP_JZ: begin
                     if (zero) pc <= op_addr;
                  end
`ifdef ACC_CPU_CARRY_EN
                  OP_JC: begin
                     if (carry) pc <= op_addr;
                  end
`endif
                  OP_HALT: state <= ST_HALT;
                  default: state <= ST_FETCH;
               endcase
            end
            ST_MEM: begin
               if (accept) begin
                  if (op != OP_STO) begin
                     acc  <= alu_result;
                     zero <= alu_zero;
                  end
                  state <= ST_FETCH;
               end
            end
            default: state <= ST_HALT;
         endcase
      end
   end

endmodule
